// File: rtl/dz_pkg.sv
// Shared definitions for the 8x8 red/green dot-matrix scan interface.
// Used by the driver, the capture monitor and the bench.
package dz_pkg;

  localparam int DZ_ROWS = 8;
  localparam int DZ_COLS = 8;

  typedef logic [2:0]         row_idx_t;
  typedef logic [DZ_COLS-1:0] col_t;

  typedef enum logic {
    ST_SYNC = 1'b0,
    ST_CAPT = 1'b1
  } dz_state_t;

  typedef struct packed {
    col_t r;
    col_t g;
  } dz_px_t;

  localparam row_idx_t DZ_LAST_ROW = row_idx_t'(DZ_ROWS - 1);

  // Row k of a pattern lives in bits [8k+7:8k].
  localparam logic [DZ_ROWS*DZ_COLS-1:0] DZ_PAT_EGG_G   = 64'h0000_183C_3C18_0000;
  localparam logic [DZ_ROWS*DZ_COLS-1:0] DZ_PAT_CRACK_R = 64'h8142_2418_1824_4281;
  localparam logic [DZ_ROWS*DZ_COLS-1:0] DZ_PAT_CHICK_G = 64'h3C42_99A5_81A5_423C;

  function automatic col_t dz_pat_row(input logic [DZ_ROWS*DZ_COLS-1:0] pat,
                                      input row_idx_t k);
    return pat[{k, 3'b000} +: DZ_COLS];
  endfunction

endpackage

// File: rtl/dz_row_decode.sv
// Classifies an active-low row strobe: single row (with index), blank, or multiple rows.
// Latency: combinational; backpressure: none.
module dz_row_decode
  import dz_pkg::*;
(
  input  logic [DZ_ROWS-1:0] row,
  output row_idx_t           idx,
  output logic               valid,
  output logic               blank,
  output logic               multi
);

  logic [3:0] zeros;

  always_comb begin
    idx   = '0;
    zeros = '0;
    for (int k = 0; k < DZ_ROWS; k++) begin
      if (!row[k]) begin
        idx   = row_idx_t'(k);
        zeros = zeros + 4'd1;
      end
    end
  end

  assign valid = (zeros == 4'd1);
  assign blank = (zeros == 4'd0);
  assign multi = (zeros > 4'd1);

endmodule

// File: rtl/dz_scan_capture.sv
// Rebuilds the displayed frame from the matrix pins; commits complete in-order scans.
// Latency: pin to flag/commit 2 edges, read port 1 edge; backpressure: none (pure monitor).
module dz_scan_capture
  import dz_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [7:0]       row_in,
  input  logic [7:0]       colr_in,
  input  logic [7:0]       colg_in,
  input  logic [2:0]       rd_row,
  output logic [7:0]       rd_r,
  output logic [7:0]       rd_g,
  output logic             frame_valid,
  output logic             frame_pulse,
  output logic [CNT_W-1:0] frame_cnt,
  output logic             err_onehot,
  output logic             err_order,
  input  logic             clr_err
);

  localparam int             WD_W   = $clog2(TIMEOUT + 1);
  localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT);

  logic [7:0] row_q, colr_q, colg_q;
  // Reset leaves row_q at zero, which would decode as a multi-row strobe.
  logic       samp_vld;

  dz_state_t       state_q, state_n;
  row_idx_t        expect_q, expect_n;
  logic [WD_W-1:0] wdog_q, wdog_n, wd_inc;

  dz_px_t shadow    [DZ_ROWS];
  dz_px_t frame_buf [DZ_ROWS];

  row_idx_t dec_idx;
  logic     dec_valid, dec_blank, dec_multi;
  logic     wr_en, commit, ev_order, ev_onehot;

  dz_row_decode u_dec (
    .row   (row_q),
    .idx   (dec_idx),
    .valid (dec_valid),
    .blank (dec_blank),
    .multi (dec_multi)
  );

  assign wd_inc = (wdog_q == WD_MAX) ? WD_MAX : wdog_q + 1'b1;

  always_comb begin
    state_n   = state_q;
    expect_n  = expect_q;
    wdog_n    = wdog_q;
    wr_en     = 1'b0;
    commit    = 1'b0;
    ev_order  = 1'b0;
    ev_onehot = 1'b0;
    if (!en) begin
      state_n  = ST_SYNC;
      expect_n = '0;
      wdog_n   = '0;
    end else if (samp_vld) begin
      ev_onehot = dec_multi;
      unique case (state_q)
        ST_SYNC: begin
          wdog_n = '0;
          if (dec_valid && dec_idx == '0) begin
            wr_en    = 1'b1;
            expect_n = 3'd1;
            state_n  = ST_CAPT;
          end
        end
        ST_CAPT: begin
          if (dec_valid) begin
            wdog_n = '0;
            if (dec_idx == expect_q) begin
              wr_en = 1'b1;
              if (dec_idx == DZ_LAST_ROW) begin
                commit   = 1'b1;
                expect_n = '0;
              end else begin
                expect_n = expect_q + 3'd1;
              end
            end else if (dec_idx == expect_q - 3'd1) begin
              wr_en = 1'b1;
            end else begin
              ev_order = 1'b1;
              // A stray row 0 is treated as the start of a fresh scan.
              if (dec_idx == '0) begin
                wr_en    = 1'b1;
                expect_n = 3'd1;
              end else begin
                state_n  = ST_SYNC;
                expect_n = '0;
              end
            end
          end else if (dec_blank || dec_multi) begin
            wdog_n = wd_inc;
            if (wd_inc == WD_MAX) begin
              state_n  = ST_SYNC;
              expect_n = '0;
              wdog_n   = '0;
            end
          end
        end
        default: state_n = ST_SYNC;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_SYNC;
      expect_q <= '0;
      wdog_q   <= '0;
    end else begin
      state_q  <= state_n;
      expect_q <= expect_n;
      wdog_q   <= wdog_n;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_q       <= '0;
      colr_q      <= '0;
      colg_q      <= '0;
      samp_vld    <= 1'b0;
      rd_r        <= '0;
      rd_g        <= '0;
      frame_valid <= 1'b0;
      frame_pulse <= 1'b0;
      frame_cnt   <= '0;
      err_onehot  <= 1'b0;
      err_order   <= 1'b0;
      for (int k = 0; k < DZ_ROWS; k++) begin
        shadow[k]    <= '0;
        frame_buf[k] <= '0;
      end
    end else begin
      row_q    <= row_in;
      colr_q   <= colr_in;
      colg_q   <= colg_in;
      samp_vld <= 1'b1;

      // Read uses the buffer as it stood before any commit on this edge.
      rd_r <= frame_buf[rd_row].r;
      rd_g <= frame_buf[rd_row].g;

      if (wr_en) shadow[dec_idx] <= '{r: colr_q, g: colg_q};

      if (commit) begin
        for (int k = 0; k < DZ_ROWS - 1; k++) frame_buf[k] <= shadow[k];
        frame_buf[DZ_LAST_ROW] <= '{r: colr_q, g: colg_q};
        frame_cnt   <= frame_cnt + 1'b1;
        frame_valid <= 1'b1;
      end
      frame_pulse <= commit;

      err_onehot <= (err_onehot & ~clr_err) | ev_onehot;
      err_order  <= (err_order  & ~clr_err) | ev_order;
    end
  end

endmodule

// File: tb/tb_dz_scan_capture.sv
// Directed bench for dz_scan_capture: scan-level reference model checked every cycle,
// plus hand-computed expectations for each scenario.
module tb_dz_scan_capture;
  import dz_pkg::*;

  localparam int TIMEOUT = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b1;
  logic [7:0] row_in = 8'hFF, colr_in = 8'h00, colg_in = 8'h00;
  logic [2:0] rd_row = 3'd0;
  logic       clr_err = 1'b0;
  logic [7:0] rd_r, rd_g;
  logic       frame_valid, frame_pulse, err_onehot, err_order;
  logic [7:0] frame_cnt;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  dz_scan_capture #(.TIMEOUT(TIMEOUT), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .en(en), .row_in(row_in), .colr_in(colr_in), .colg_in(colg_in),
    .rd_row(rd_row), .rd_r(rd_r), .rd_g(rd_g), .frame_valid(frame_valid),
    .frame_pulse(frame_pulse), .frame_cnt(frame_cnt), .err_onehot(err_onehot),
    .err_order(err_order), .clr_err(clr_err)
  );

  logic [7:0] t_row;
  row_idx_t   t_idx;
  logic       t_valid, t_blank, t_multi;
  dz_row_decode u_tdec (.row(t_row), .idx(t_idx), .valid(t_valid), .blank(t_blank), .multi(t_multi));

  logic [7:0] dec_vec [5] = '{8'hFE, 8'h7F, 8'hEF, 8'hFF, 8'hFC};
  int         dec_exp_idx [5] = '{0, 7, 4, 0, 0};
  int         dec_exp_cls [5] = '{0, 0, 0, 1, 2}; // 0 single, 1 blank, 2 multi

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- scan-level reference model ----------------
  int         m_next;      // row expected next; -1 while waiting for row 0
  int         m_idle;
  bit         m_have;
  logic [7:0] m_row, m_r, m_g;
  logic [7:0] m_sh_r [8], m_sh_g [8], m_buf_r [8], m_buf_g [8];
  logic [7:0] m_rd_r, m_rd_g;
  bit         m_pulse, m_valid, m_eoh, m_eor;
  int         m_cnt;

  task automatic m_store(input int k);
    m_sh_r[k] = m_r;
    m_sh_g[k] = m_g;
  endtask

  always @(posedge clk or posedge rst) begin
    int  zeros, k;
    bit  ev_oh, ev_or;
    if (rst) begin
      m_next = -1; m_idle = 0; m_have = 0;
      m_row = 0; m_r = 0; m_g = 0; m_rd_r = 0; m_rd_g = 0;
      m_pulse = 0; m_valid = 0; m_eoh = 0; m_eor = 0; m_cnt = 0;
      for (int i = 0; i < 8; i++) begin
        m_sh_r[i] = 0; m_sh_g[i] = 0; m_buf_r[i] = 0; m_buf_g[i] = 0;
      end
    end else begin
      m_rd_r = m_buf_r[rd_row];
      m_rd_g = m_buf_g[rd_row];
      m_pulse = 0; ev_oh = 0; ev_or = 0;
      if (!en) begin
        m_next = -1; m_idle = 0;
      end else if (m_have) begin
        zeros = $countones(~m_row);
        k = 0;
        for (int b = 0; b < 8; b++) if (!m_row[b]) k = b;
        if (zeros > 1) ev_oh = 1;
        if (zeros == 1) begin
          m_idle = 0;
          if (m_next < 0) begin
            if (k == 0) begin m_store(0); m_next = 1; end
          end else if (k == m_next) begin
            m_store(k);
            if (k == 7) begin
              for (int i = 0; i < 8; i++) begin m_buf_r[i] = m_sh_r[i]; m_buf_g[i] = m_sh_g[i]; end
              m_cnt = (m_cnt + 1) % 256; m_valid = 1; m_pulse = 1; m_next = 0;
            end else m_next = k + 1;
          end else if (k == (m_next + 7) % 8) begin
            m_store(k);
          end else begin
            ev_or = 1;
            if (k == 0) begin m_store(0); m_next = 1; end
            else m_next = -1;
          end
        end else if (m_next >= 0) begin
          m_idle++;
          if (m_idle >= TIMEOUT) begin m_next = -1; m_idle = 0; end
        end
      end
      m_eoh = (m_eoh && !clr_err) || ev_oh;
      m_eor = (m_eor && !clr_err) || ev_or;
      m_have = 1; m_row = row_in; m_r = colr_in; m_g = colg_in;
    end
  end

  always @(negedge clk) begin
    chk("rd_r", {8'h0, rd_r}, {8'h0, m_rd_r});
    chk("rd_g", {8'h0, rd_g}, {8'h0, m_rd_g});
    chk("frame_valid", {15'h0, frame_valid}, {15'h0, m_valid});
    chk("frame_pulse", {15'h0, frame_pulse}, {15'h0, m_pulse});
    chk("frame_cnt", {8'h0, frame_cnt}, m_cnt[15:0]);
    chk("err_onehot", {15'h0, err_onehot}, {15'h0, m_eoh});
    chk("err_order", {15'h0, err_order}, {15'h0, m_eor});
  end

  // ---------------- stimulus helpers ----------------
  task automatic drive(input logic [7:0] row, input logic [7:0] r, input logic [7:0] g);
    @(negedge clk);
    row_in = row; colr_in = r; colg_in = g;
  endtask

  task automatic scan_row(input int k, input logic [7:0] r, input logic [7:0] g);
    logic [7:0] one;
    one = 8'b1 << k;
    drive(~one, r, g);
  endtask

  task automatic frame(input logic [63:0] pr, input logic [63:0] pg);
    for (int k = 0; k < 8; k++)
      scan_row(k, dz_pat_row(pr, row_idx_t'(k)), dz_pat_row(pg, row_idx_t'(k)));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(8'hFF, 8'h00, 8'h00);
  endtask

  task automatic rd_chk(input int row, input logic [7:0] er, input logic [7:0] eg);
    @(negedge clk);
    rd_row = row[2:0];
    @(negedge clk);
    chk("rd_lit_r", {8'h0, rd_r}, {8'h0, er});
    chk("rd_lit_g", {8'h0, rd_g}, {8'h0, eg});
  endtask

  task automatic pulse_clr();
    @(negedge clk); clr_err = 1'b1;
    @(negedge clk); clr_err = 1'b0;
  endtask

  task automatic chk_outs_zero(input string nm);
    chk(nm, {rd_r, rd_g}, 16'h0);
    chk(nm, {5'h0, frame_valid, frame_pulse, err_onehot, frame_cnt}, 16'h0);
    chk(nm, {15'h0, err_order}, 16'h0);
  endtask

  initial begin
    for (int i = 0; i < 5; i++) begin
      t_row = dec_vec[i];
      #1;
      chk("dec_valid", {15'h0, t_valid}, {15'h0, dec_exp_cls[i] == 0});
      chk("dec_blank", {15'h0, t_blank}, {15'h0, dec_exp_cls[i] == 1});
      chk("dec_multi", {15'h0, t_multi}, {15'h0, dec_exp_cls[i] == 2});
      if (dec_exp_cls[i] == 0) chk("dec_idx", {13'h0, t_idx}, dec_exp_idx[i][15:0]);
    end

    repeat (3) @(negedge clk);
    chk_outs_zero("reset_state");
    rst = 1'b0;
    idle(2);

    // clean frame
    frame(64'h0, DZ_PAT_EGG_G);
    idle(3);
    chk("clean_cnt", {8'h0, frame_cnt}, 16'd1);
    chk("clean_valid", {15'h0, frame_valid}, 16'd1);
    rd_chk(3, 8'h00, 8'h3C);
    rd_chk(2, 8'h00, 8'h18);

    // mid-frame start
    idle(20);
    for (int k = 4; k < 8; k++) scan_row(k, 8'hEE, 8'hEE);
    frame(DZ_PAT_CRACK_R, DZ_PAT_CHICK_G);
    idle(3);
    chk("mid_cnt", {8'h0, frame_cnt}, 16'd2);
    chk("mid_order", {15'h0, err_order}, 16'd0);
    rd_chk(3, 8'h18, 8'h81);
    rd_chk(0, 8'h81, 8'h3C);

    // multiple rows low
    drive(8'hFC, 8'h55, 8'h55);
    idle(3);
    chk("multi_flag", {15'h0, err_onehot}, 16'd1);
    chk("multi_cnt", {8'h0, frame_cnt}, 16'd2);
    rd_chk(3, 8'h18, 8'h81);
    pulse_clr();
    chk("multi_clr", {15'h0, err_onehot}, 16'd0);
    drive(8'hFC, 8'h55, 8'h55);
    @(negedge clk); row_in = 8'hFF; clr_err = 1'b1;
    @(negedge clk); clr_err = 1'b0;
    chk("multi_clr_race", {15'h0, err_onehot}, 16'd1);
    pulse_clr();
    chk("multi_clr2", {15'h0, err_onehot}, 16'd0);

    // out of order
    idle(20);
    scan_row(0, 8'hAA, 8'hAA); scan_row(1, 8'hAA, 8'hAA);
    scan_row(2, 8'hAA, 8'hAA); scan_row(4, 8'hAA, 8'hAA);
    idle(2);
    chk("ooo_flag", {15'h0, err_order}, 16'd1);
    chk("ooo_cnt", {8'h0, frame_cnt}, 16'd2);
    rd_chk(3, 8'h18, 8'h81);
    pulse_clr();
    chk("ooo_clr", {15'h0, err_order}, 16'd0);

    // repeated row
    for (int k = 0; k < 3; k++)
      scan_row(k, dz_pat_row(DZ_PAT_EGG_G, row_idx_t'(k)), dz_pat_row(DZ_PAT_CRACK_R, row_idx_t'(k)));
    scan_row(2, 8'h5A, 8'hA5);
    for (int k = 3; k < 8; k++)
      scan_row(k, dz_pat_row(DZ_PAT_EGG_G, row_idx_t'(k)), dz_pat_row(DZ_PAT_CRACK_R, row_idx_t'(k)));
    idle(3);
    chk("rep_order", {15'h0, err_order}, 16'd0);
    chk("rep_cnt", {8'h0, frame_cnt}, 16'd3);
    rd_chk(2, 8'h5A, 8'hA5);
    rd_chk(3, 8'h3C, 8'h18);

    // stall of exactly TIMEOUT blank cycles abandons the scan
    for (int k = 0; k < 4; k++) scan_row(k, 8'h77, 8'h77);
    idle(16);
    for (int k = 4; k < 8; k++) scan_row(k, 8'h66, 8'h66);
    idle(3);
    chk("stall_cnt", {8'h0, frame_cnt}, 16'd3);
    chk("stall_err", {14'h0, err_order, err_onehot}, 16'd0);
    rd_chk(3, 8'h3C, 8'h18);

    // one cycle short of the timeout still commits
    for (int k = 0; k < 4; k++) scan_row(k, 8'h11, 8'h22);
    idle(15);
    for (int k = 4; k < 8; k++) scan_row(k, 8'h33, 8'h44);
    idle(3);
    chk("wd15_cnt", {8'h0, frame_cnt}, 16'd4);
    rd_chk(3, 8'h11, 8'h22);
    rd_chk(7, 8'h33, 8'h44);

    // enable dropped mid-scan
    for (int k = 0; k < 4; k++) scan_row(k, 8'h55, 8'h55);
    @(negedge clk); en = 1'b0; row_in = 8'hFF;
    @(negedge clk); en = 1'b1;
    for (int k = 4; k < 8; k++) scan_row(k, 8'h55, 8'h55);
    idle(3);
    chk("en_cnt", {8'h0, frame_cnt}, 16'd4);
    rd_chk(3, 8'h11, 8'h22);

    // asynchronous reset mid-scan
    for (int k = 0; k < 4; k++) scan_row(k, 8'h99, 8'h99);
    @(posedge clk); #2 rst = 1'b1;
    #1 chk_outs_zero("rst_async");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int r = 0; r < 8; r++) rd_chk(r, 8'h00, 8'h00);

    // counter wrap
    for (int f = 0; f < 255; f++) frame(DZ_PAT_CRACK_R, DZ_PAT_EGG_G);
    idle(2);
    chk("wrap_255", {8'h0, frame_cnt}, 16'd255);
    frame(DZ_PAT_CRACK_R, DZ_PAT_EGG_G);
    idle(2);
    chk("wrap_0", {8'h0, frame_cnt}, 16'd0);
    chk("wrap_valid", {15'h0, frame_valid}, 16'd1);
    rd_chk(3, 8'h18, 8'h3C);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
